execute_stage: RTL

Execute (EXE) stage of the 5-stage ARM32 pipeline, placed directly downstream of the ID stage and its ID/EXE pipeline register. Consumes the registered decode bundle and resolves operand forwarding. Computes Val2 (shifter operand), runs the ALU, updates the NZCV status register, and produces the branch target. Results are captured in the EXE/MEM pipeline register, which holds under cache freeze.

---
 rtl/execute_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// EXE stage: operand forwarding, shifter operand (Val2), ALU, NZCV status and branch target.
// Latency 1 cycle into the EXE/MEM register; freeze holds all state, branch outputs are combinational.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_EXE,
  input  logic [31:0] rn_val_EXE,
  input  logic [31:0] rm_val_EXE,
  input  logic [23:0] signed_imm_24_EXE,
  input  logic [11:0] shifter_operand_EXE,
  input  logic [3:0]  exe_cmd_EXE,
  input  logic [3:0]  dest_EXE,
  input  logic        WB_EN_EXE,
  input  logic        MEM_R_EN_EXE,
  input  logic        MEM_W_EN_EXE,
  input  logic        S_EXE,
  input  logic        B_EXE,
  input  logic        imm_EXE,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] wb_val_WB,
  output logic [3:0]  status_ID,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [31:0] alu_res_MEM,
  output logic [31:0] st_val_MEM,
  output logic [3:0]  dest_MEM,
  output logic        WB_EN_MEM,
  output logic        MEM_R_EN_MEM,
  output logic        MEM_W_EN_MEM
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [31:0] op_a;
  logic [31:0] op_m;
  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [32:0] sum;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        flag_upd;
  logic        cin;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    if (amt == 5'd0) return v;
    return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
  endfunction

  // Forwarding muxes; code 11 falls back to the register-file value.
  always_comb begin
    case (sel_src1)
      2'b01:   op_a = alu_res_MEM;
      2'b10:   op_a = wb_val_WB;
      default: op_a = rn_val_EXE;
    endcase
    case (sel_src2)
      2'b01:   op_m = alu_res_MEM;
      2'b10:   op_m = wb_val_WB;
      default: op_m = rm_val_EXE;
    endcase
  end

  always_comb begin
    logic [4:0] sh_amt;
    sh_amt = shifter_operand_EXE[11:7];
    val2   = op_m;
    if (MEM_R_EN_EXE || MEM_W_EN_EXE) begin
      val2 = {20'b0, shifter_operand_EXE};
    end else if (imm_EXE) begin
      val2 = ror32({24'b0, shifter_operand_EXE[7:0]}, {shifter_operand_EXE[11:8], 1'b0});
    end else if (sh_amt != 5'd0) begin
      case (shifter_operand_EXE[6:5])
        2'b00:   val2 = op_m << sh_amt;
        2'b01:   val2 = op_m >> sh_amt;
        2'b10:   val2 = $unsigned($signed(op_m) >>> sh_amt);
        default: val2 = ror32(op_m, sh_amt);
      endcase
    end
  end

  assign cin = status_ID[1];

  always_comb begin
    sum      = 33'd0;
    alu_res  = 32'd0;
    flag_c   = status_ID[1];
    flag_v   = status_ID[0];
    flag_upd = 1'b1;
    case (exe_cmd_EXE)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = op_a & val2;
      CMD_ORR: alu_res = op_a | val2;
      CMD_EOR: alu_res = op_a ^ val2;
      CMD_ADD, CMD_ADC: begin
        sum     = {1'b0, op_a} + {1'b0, val2}
                  + {32'd0, (exe_cmd_EXE == CMD_ADC) ? cin : 1'b0};
        alu_res = sum[31:0];
        flag_c  = sum[32];
        flag_v  = (op_a[31] == val2[31]) && (alu_res[31] != op_a[31]);
      end
      CMD_SUB, CMD_SBC: begin
        // Two's-complement subtract; carry-out is the ARM no-borrow flag.
        sum     = {1'b0, op_a} + {1'b0, ~val2}
                  + {32'd0, (exe_cmd_EXE == CMD_SBC) ? cin : 1'b1};
        alu_res = sum[31:0];
        flag_c  = sum[32];
        flag_v  = (op_a[31] != val2[31]) && (alu_res[31] != op_a[31]);
      end
      default: flag_upd = 1'b0;
    endcase
    flag_n = alu_res[31];
    flag_z = (alu_res == 32'd0);
  end

  assign branch_taken = B_EXE;
  assign branch_addr  = pc_EXE + {{6{signed_imm_24_EXE[23]}}, signed_imm_24_EXE, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_ID <= 4'd0;
    end else if (!freeze && S_EXE && !B_EXE && flag_upd) begin
      status_ID <= {flag_n, flag_z, flag_c, flag_v};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res_MEM  <= 32'd0;
      st_val_MEM   <= 32'd0;
      dest_MEM     <= 4'd0;
      WB_EN_MEM    <= 1'b0;
      MEM_R_EN_MEM <= 1'b0;
      MEM_W_EN_MEM <= 1'b0;
    end else if (!freeze) begin
      alu_res_MEM  <= alu_res;
      st_val_MEM   <= op_m;
      dest_MEM     <= dest_EXE;
      WB_EN_MEM    <= WB_EN_EXE;
      MEM_R_EN_MEM <= MEM_R_EN_EXE;
      MEM_W_EN_MEM <= MEM_W_EN_EXE;
    end
  end

endmodule
